// File: rtl/dmem_map_pkg.sv
// Shared address-map constants and helpers for the data-memory / MMIO responder.
// Offsets are relative to the MMIO window base word address.
package dmem_map_pkg;

    localparam logic [1:0] OFF_OUT    = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;
    localparam logic [1:0] OFF_ERR    = 2'd3;

    localparam int STAT_OVF_BIT   = 8;
    localparam int STAT_FULL_BIT  = 7;
    localparam int STAT_EMPTY_BIT = 6;
    localparam int STAT_COUNT_W   = 6;

    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        RGN_NONE     = 2'd0,
        RGN_RAM      = 2'd1,
        RGN_MMIO     = 2'd2,
        RGN_UNMAPPED = 2'd3
    } region_e;

    function automatic logic [31:0] pack_status(
        input logic                    ovf,
        input logic                    full,
        input logic                    empty,
        input logic [STAT_COUNT_W-1:0] count
    );
        logic [31:0] w;
        w                      = 32'h0000_0000;
        w[STAT_OVF_BIT]        = ovf;
        w[STAT_FULL_BIT]       = full;
        w[STAT_EMPTY_BIT]      = empty;
        w[STAT_COUNT_W-1:0]    = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with sticky overflow flag; head word reads as zero when empty.
// A push into a full FIFO is accepted only if a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr_overflow,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             overflow_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Occupancy flags and the accepted push/pop strobes.
    always_comb begin
        full_s    = (count_r == (AW+1)'(DEPTH));
        empty_s   = (count_r == (AW+1)'(0));
        do_pop_s  = pop && !empty_s;
        do_push_s = push && (!full_s || do_pop_s);
    end

    // Pointer, count and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            count_r    <= (AW+1)'(0);
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
            if (clr_overflow) begin
                overflow_r <= 1'b0;
            end else if (push && !do_push_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout     = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for a single-cycle core: word RAM plus an MMIO window
// with an output FIFO, a free-running cycle counter and first-error capture.
module dmem_mmio_responder
    import dmem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        mem_error
);

    localparam int RAM_AW  = $clog2(RAM_WORDS);
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]        ram_r [RAM_WORDS];
    logic [31:0]        cycle_r;
    logic [31:0]        err_addr_r;
    logic               mem_error_r;

    region_e            region_s;
    logic [31:0]        mmio_diff_s;
    logic [1:0]         mmio_off_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic               ram_we_s;
    logic               push_s;
    logic               status_we_s;
    logic               cycle_we_s;
    logic               err_we_s;
    logic [31:0]        rd_data_s;

    logic [31:0]        fifo_dout_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [FIFO_CW-1:0] fifo_count_s;
    logic               fifo_ovf_s;

    // Address decode; the modular difference keeps a window at the top of memory valid.
    always_comb begin
        mmio_diff_s = Address - MMIO_BASE;
        mmio_off_s  = mmio_diff_s[1:0];
        ram_idx_s   = Address[RAM_AW-1:0];
        if (!(MemRead || MemWrite)) begin
            region_s = RGN_NONE;
        end else if (Address < 32'(RAM_WORDS)) begin
            region_s = RGN_RAM;
        end else if (mmio_diff_s < 32'd4) begin
            region_s = RGN_MMIO;
        end else begin
            region_s = RGN_UNMAPPED;
        end
        ram_we_s    = MemWrite && (region_s == RGN_RAM);
        push_s      = MemWrite && (region_s == RGN_MMIO) && (mmio_off_s == OFF_OUT);
        status_we_s = MemWrite && (region_s == RGN_MMIO) && (mmio_off_s == OFF_STATUS);
        cycle_we_s  = MemWrite && (region_s == RGN_MMIO) && (mmio_off_s == OFF_CYCLE);
        err_we_s    = MemWrite && (region_s == RGN_MMIO) && (mmio_off_s == OFF_ERR);
    end

    // Combinational load path; all sources are pre-edge state, so a same-cycle store is not visible.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (!MemRead) begin
            rd_data_s = 32'h0000_0000;
        end else begin
            case (region_s)
                RGN_RAM:  rd_data_s = ram_r[ram_idx_s];
                RGN_MMIO: begin
                    case (mmio_off_s)
                        OFF_OUT:    rd_data_s = 32'h0000_0000;
                        OFF_STATUS: rd_data_s = pack_status(fifo_ovf_s, fifo_full_s, fifo_empty_s,
                                                            STAT_COUNT_W'(fifo_count_s));
                        OFF_CYCLE:  rd_data_s = cycle_r;
                        OFF_ERR:    rd_data_s = err_addr_r;
                        default:    rd_data_s = 32'h0000_0000;
                    endcase
                end
                RGN_UNMAPPED: rd_data_s = UNMAPPED_DATA;
                default:      rd_data_s = 32'h0000_0000;
            endcase
        end
    end

    // RAM storage; contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= WriteData;
        end
    end

    // Free-running cycle counter, loadable from the core.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_r <= 32'h0000_0000;
        end else if (cycle_we_s) begin
            cycle_r <= WriteData;
        end else begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // Sticky error flag with first-address capture; an explicit clear takes priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_error_r <= 1'b0;
            err_addr_r  <= 32'h0000_0000;
        end else if (err_we_s) begin
            mem_error_r <= 1'b0;
            err_addr_r  <= 32'h0000_0000;
        end else if ((region_s == RGN_UNMAPPED) && !mem_error_r) begin
            mem_error_r <= 1'b1;
            err_addr_r  <= Address;
        end else begin
            mem_error_r <= mem_error_r;
            err_addr_r  <= err_addr_r;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk          (CLK),
        .rst          (RST),
        .push         (push_s),
        .pop          (out_ready && !fifo_empty_s),
        .clr_overflow (status_we_s),
        .din          (WriteData),
        .dout         (fifo_dout_s),
        .full         (fifo_full_s),
        .empty        (fifo_empty_s),
        .count        (fifo_count_s),
        .overflow     (fifo_ovf_s)
    );

    assign ReadData  = rd_data_s;
    assign out_data  = fifo_dout_s;
    assign out_valid = !fifo_empty_s;
    assign mem_error = mem_error_r;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, FIFO, cycle counter and error capture.
module tb_dmem_mmio_responder;

    localparam logic [31:0] BASE     = 32'hFFFF_FF00;
    localparam logic [31:0] A_OUT    = BASE + 32'd0;
    localparam logic [31:0] A_STATUS = BASE + 32'd1;
    localparam logic [31:0] A_CYCLE  = BASE + 32'd2;
    localparam logic [31:0] A_ERR    = BASE + 32'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        mem_error;

    int tests_run = 0;
    int tests_failed = 0;

    dmem_mmio_responder #(
        .RAM_WORDS  (256),
        .FIFO_DEPTH (4),
        .MMIO_BASE  (BASE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_error (mem_error)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        Address = addr;
        MemRead = 1'b1;
        #1;
        check_eq(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    task automatic drain_check(input string tag, input logic [31:0] first);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq(tag, out_data, first + 32'(i));
            tick();
        end
        out_ready = 1'b0;
        #1;
        check_eq({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; Address = 32'd0; WriteData = 32'd0;
        MemWrite = 1'b0; MemRead = 1'b0; out_ready = 1'b0;

        // 1. reset
        tick(); tick();
        RST = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_err",   {31'd0, mem_error}, 32'd0);
        check_eq("rst_odata", out_data, 32'd0);
        rd_check("rst_status", A_STATUS, 32'h0000_0040);
        rd_check("rst_cycle",  A_CYCLE,  32'd0);

        // 2. RAM
        wr(32'd5, 32'h0000_1234);
        rd_check("ram_rd5", 32'd5, 32'h0000_1234);
        Address = 32'd5; MemRead = 1'b0; #1;
        check_eq("ram_noread", ReadData, 32'd0);
        Address = 32'd5; WriteData = 32'h0000_AAAA; MemRead = 1'b1; MemWrite = 1'b1; #1;
        check_eq("rw_prewrite", ReadData, 32'h0000_1234);
        tick();
        MemWrite = 1'b0; MemRead = 1'b0;
        rd_check("rw_commit", 32'd5, 32'h0000_AAAA);

        // 3. FIFO overflow then drain
        for (int i = 1; i <= 5; i++) wr(A_OUT, 32'(i));
        rd_check("fifo_full_status", A_STATUS, 32'h0000_0184);
        rd_check("out_reads_zero", A_OUT, 32'd0);
        drain_check("drain1", 32'd1);

        // 4. full with simultaneous push and pop
        for (int i = 5; i <= 8; i++) wr(A_OUT, 32'(i));
        out_ready = 1'b1;
        wr(A_OUT, 32'd9);
        out_ready = 1'b0;
        #1;
        check_eq("pushpop_head", out_data, 32'd6);
        rd_check("pushpop_status", A_STATUS, 32'h0000_0184);
        drain_check("drain2", 32'd6);
        wr(A_STATUS, 32'hFFFF_FFFF);
        rd_check("ovf_cleared", A_STATUS, 32'h0000_0040);

        // empty push with ready: no bypass
        out_ready = 1'b1;
        #1;
        check_eq("nobypass_pre", {31'd0, out_valid}, 32'd0);
        wr(A_OUT, 32'h0000_0077);
        #1;
        check_eq("nobypass_valid", {31'd0, out_valid}, 32'd1);
        check_eq("nobypass_data", out_data, 32'h0000_0077);
        tick();
        out_ready = 1'b0;
        check_eq("nobypass_popped", {31'd0, out_valid}, 32'd0);

        // 5. unmapped accesses
        wr(32'd0, 32'h0000_0055);
        Address = 32'h0001_0000; MemRead = 1'b1; #1;
        check_eq("unmapped_data", ReadData, 32'hDEAD_BEEF);
        tick();
        MemRead = 1'b0; #1;
        check_eq("err_set", {31'd0, mem_error}, 32'd1);
        rd_check("err_addr", A_ERR, 32'h0001_0000);
        Address = 32'h0002_0000; MemRead = 1'b1; tick(); MemRead = 1'b0;
        rd_check("err_addr_held", A_ERR, 32'h0001_0000);
        wr(A_ERR, 32'd0);
        #1;
        check_eq("err_cleared", {31'd0, mem_error}, 32'd0);
        rd_check("err_addr_cleared", A_ERR, 32'd0);
        wr(32'd256, 32'h0000_BAD0);
        rd_check("unmapped_wr_ignored", 32'd0, 32'h0000_0055);
        rd_check("err_addr_256", A_ERR, 32'd256);
        wr(A_ERR, 32'd0);

        // 6. cycle wrap and reset mid-drain
        wr(A_CYCLE, 32'hFFFF_FFFE);
        rd_check("cycle_loaded", A_CYCLE, 32'hFFFF_FFFE);
        tick(); tick(); tick();
        rd_check("cycle_wrap", A_CYCLE, 32'd1);
        wr(A_OUT, 32'h0000_00A1);
        wr(A_OUT, 32'h0000_00A2);
        out_ready = 1'b1;
        tick();
        #1;
        check_eq("middrain_valid", {31'd0, out_valid}, 32'd1);
        check_eq("middrain_data", out_data, 32'h0000_00A2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_data", out_data, 32'd0);
        rd_check("flush_status", A_STATUS, 32'h0000_0040);
        rd_check("flush_cycle", A_CYCLE, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
